// File: rtl/s2a_burst_writer_if.sv
// Stream-in and AXI write-channel bundle for s2a_burst_writer.
// master = the burst writer, slave = stream source plus AXI slave port.
`timescale 1ns/1ps
interface s2a_burst_writer_if #(
    parameter int DATA_W = 64
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [31:0]       AXI_awaddr;
    logic [7:0]        AXI_awlen;
    logic [2:0]        AXI_awsize;
    logic [1:0]        AXI_awburst;
    logic              AXI_awvalid;
    logic              AXI_awready;
    logic [DATA_W-1:0] AXI_wdata;
    logic              AXI_wvalid;
    logic              AXI_wready;
    logic              AXI_wlast;
    logic              AXI_bvalid;
    logic [1:0]        AXI_bresp;
    logic              AXI_bready;

    modport master (
        input  s_valid, s_data, AXI_awready, AXI_wready, AXI_bvalid, AXI_bresp,
        output s_ready, AXI_awaddr, AXI_awlen, AXI_awsize, AXI_awburst, AXI_awvalid,
               AXI_wdata, AXI_wvalid, AXI_wlast, AXI_bready
    );

    modport slave (
        output s_valid, s_data, AXI_awready, AXI_wready, AXI_bvalid, AXI_bresp,
        input  s_ready, AXI_awaddr, AXI_awlen, AXI_awsize, AXI_awburst, AXI_awvalid,
               AXI_wdata, AXI_wvalid, AXI_wlast, AXI_bready
    );
endinterface

// File: rtl/s2a_burst_writer.sv
// Stream-to-AXI write controller: buffers stream words in a show-ahead FIFO and writes
// them as fixed-length INCR bursts into a circular OCM window, one burst outstanding.
`timescale 1ns/1ps
module s2a_burst_writer #(
    parameter logic [31:0] OCM_HADDR = 32'hFFFC0000,
    parameter int          OCM_WIDTH = 16,
    parameter int          DATA_W    = 64,
    parameter int          BURST_LEN = 16,
    parameter int          FIFO_AW   = 5
) (
    input  logic               AXI_clk,
    input  logic               rst_n,
    input  logic               sync,
    s2a_burst_writer_if.master bus,
    output logic [31:0]        s2a_cnt,
    output logic               ovf,
    output logic               err
);
    localparam int DEPTH       = 2 ** FIFO_AW;
    localparam int PTR_W       = FIFO_AW + 1;
    localparam int BEAT_W      = $clog2(BURST_LEN);
    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;

    localparam logic [PTR_W-1:0]     BURST_FILL = PTR_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    // Truncation to the window width makes the ring offset wrap for free.
    localparam logic [OCM_WIDTH-1:0] OFF_STEP   = OCM_WIDTH'(BURST_BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [OCM_WIDTH-1:0] off_q, off_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic                 pend_q, pend_d;
    logic [PTR_W-1:0]     fill;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 clear;

    // Pointers carry one extra bit, so fill == DEPTH is the only value with the MSB set.
    assign fill = wr_ptr_q - rd_ptr_q;
    assign full = fill[PTR_W-1];

    assign bus.s_ready     = !full && !pend_q;
    assign push            = bus.s_valid && bus.s_ready;
    assign pop             = bus.AXI_wvalid && bus.AXI_wready;

    assign bus.AXI_awlen   = 8'(BURST_LEN - 1);
    assign bus.AXI_awsize  = 3'($clog2(DATA_W / 8));
    assign bus.AXI_awburst = 2'b01;
    assign bus.AXI_awaddr  = OCM_HADDR + 32'(off_q);
    assign bus.AXI_awvalid = (state_q == ADDR);
    assign bus.AXI_wvalid  = (state_q == DATA);
    assign bus.AXI_wlast   = (state_q == DATA) && (beat_q == LAST_BEAT);
    assign bus.AXI_bready  = (state_q == RESP);
    assign bus.AXI_wdata   = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    assign s2a_cnt = cnt_q;
    assign ovf     = ovf_q;
    assign err     = err_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        pend_d   = pend_q;
        clear    = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (bus.s_valid && !bus.s_ready) ovf_d = 1'b1;
        // Outside IDLE a restart must wait so no AXI handshake is abandoned.
        if (sync && state_q != IDLE) pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (sync || pend_q) begin
                    clear = 1'b1;
                end else if (fill >= BURST_FILL) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.AXI_awready) begin
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (pop) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = RESP;
                end
            end
            RESP: begin
                if (bus.AXI_bvalid) begin
                    if (bus.AXI_bresp != 2'b00) err_d = 1'b1;
                    off_d   = off_q + OFF_STEP;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = IDLE;
                end
            end
        endcase

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            off_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            err_d    = 1'b0;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge AXI_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
        end
    end

    // Storage holds data only; validity is tracked by the pointers.
    always_ff @(posedge AXI_clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= bus.s_data;
    end
endmodule
